bmp_xfer_unit: RTL and testbench

Bitmap load/store engine feeding and draining the execute stage's 1536-bit bitmap path. On a load it reads 64 rows of 24 bits from bitmap memory and presents them as a full `bs_data` word for `exe_stage`. On a store it serialises an `exe_stage` `bd_data` result into 64 row writes. It sits between the execute stage and the bitmap memory port, and stalls the pipeline through `busy`.

---
 rtl/cpu_bmp_pkg.sv | 24 ++
 rtl/bmp_row_sel.sv | 22 ++
 rtl/bmp_xfer_unit.sv | 142 ++++++++++++++
 tb/tb_bmp_xfer_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bmp_pkg.sv
// -----------------------------------------------------------------------------
// cpu_bmp_pkg
// Shared definitions for the bitmap load/store path: bitmap geometry, the
// transfer FSM state type and the row-slice index helper used to locate a row
// inside a flattened bitmap word (row 0 is the MSB row).
// -----------------------------------------------------------------------------
package cpu_bmp_pkg;

  localparam int BMP_ROWS = 64;
  localparam int BMP_COLS = 24;
  localparam int BMP_W    = BMP_ROWS * BMP_COLS;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } bmp_state_e;

  // LSB position of row `row` in a flattened rows*cols bitmap word.
  function automatic int row_lsb(input int row, input int rows, input int cols);
    return (rows - 1 - row) * cols;
  endfunction

endpackage

// File: rtl/bmp_row_sel.sv
// -----------------------------------------------------------------------------
// bmp_row_sel
// Combinational ROWS:1 row multiplexer: extracts one COLS-bit row from a
// flattened bitmap word.
//   word  in   ROWS*COLS  bitmap word, row 0 in the MSBs
//   row   in   log2(ROWS) row index
//   data  out  COLS       selected row
// -----------------------------------------------------------------------------
module bmp_row_sel
  import cpu_bmp_pkg::*;
#(
  parameter int ROWS = BMP_ROWS,
  parameter int COLS = BMP_COLS
) (
  input  logic [ROWS*COLS-1:0]     word,
  input  logic [$clog2(ROWS)-1:0]  row,
  output logic [COLS-1:0]          data
);

  assign data = word[row_lsb(int'(row), ROWS, COLS) +: COLS];

endmodule

// File: rtl/bmp_xfer_unit.sv
// -----------------------------------------------------------------------------
// bmp_xfer_unit
// Bitmap load/store engine between the execute stage and bitmap memory.
// A load reads ROWS rows into a staging register and publishes the whole
// bitmap on bs_data atomically when the transfer finishes; a store writes the
// captured bd_data out one row per acknowledged beat.
//   clk, rst_n       clock, asynchronous active-low reset
//   start            begin transfer (accepted in IDLE and DONE)
//   is_store         1 = store bd_data, 0 = load into bs_data
//   base_addr        address of row 0
//   bd_data          bitmap to store
//   bs_data          last completed loaded bitmap
//   busy             transfer in progress (XFER)
//   done             one-cycle pulse after the final beat
//   mem_req/mem_we   request valid / write enable
//   mem_addr         row address (base_addr + row, wraps)
//   mem_wdata        row write data
//   mem_rdata        row read data, valid with mem_ack
//   mem_ack          beat accepted this cycle
// -----------------------------------------------------------------------------
module bmp_xfer_unit
  import cpu_bmp_pkg::*;
#(
  parameter int ROWS = BMP_ROWS,
  parameter int COLS = BMP_COLS,
  parameter int AW   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_store,
  input  logic [AW-1:0]        base_addr,
  input  logic [ROWS*COLS-1:0] bd_data,
  output logic [ROWS*COLS-1:0] bs_data,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [COLS-1:0]      mem_wdata,
  input  logic [COLS-1:0]      mem_rdata,
  input  logic                 mem_ack
);

  localparam int W  = ROWS * COLS;
  localparam int CW = $clog2(ROWS);

  bmp_state_e     state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           store_sh;
  logic [AW-1:0]  base_sh;
  logic [W-1:0]   bd_sh;
  logic [W-1:0]   staging, staging_upd;
  logic           capture, beat, last_beat;

  assign last_beat = (cnt == CW'(ROWS - 1));

  // NOTE: every signal driven here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    beat      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (mem_ack) begin
          beat = 1'b1;
          if (last_beat) state_nxt = DONE;
        end
      end
      DONE: begin
        // DONE behaves like IDLE for a new start, giving back-to-back transfers.
        if (start) begin
          capture   = 1'b1;
          state_nxt = XFER;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      store_sh <= 1'b0;
      base_sh  <= '0;
      bd_sh    <= '0;
      bs_data  <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        store_sh <= is_store;
        base_sh  <= base_addr;
        bd_sh    <= bd_data;
        cnt      <= '0;
      end else if (beat) begin
        cnt <= cnt + CW'(1);
      end
      // Publish on entry to DONE, merging the final row in the same edge.
      if (beat && last_beat && !store_sh) bs_data <= staging_upd;
    end
  end

  // Staging with the current beat's row replaced by the returned data.
  always_comb begin
    staging_upd = staging;
    staging_upd[row_lsb(int'(cnt), ROWS, COLS) +: COLS] = mem_rdata;
  end

  // NOTE: the staging register has no reset: every row is rewritten before
  // it is ever published, and an aborted load is simply never copied out.
  always_ff @(posedge clk) begin
    if (beat && !store_sh) staging <= staging_upd;
  end

  assign busy     = (state == XFER);
  assign done     = (state == DONE);
  assign mem_req  = busy;
  assign mem_we   = busy && store_sh;
  assign mem_addr = base_sh + AW'(cnt);

  bmp_row_sel #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_row_sel (
    .word (bd_sh),
    .row  (cnt),
    .data (mem_wdata)
  );

endmodule

// File: tb/tb_bmp_xfer_unit.sv
// -----------------------------------------------------------------------------
// tb_bmp_xfer_unit
// Directed self-checking bench for bmp_xfer_unit. A behavioural memory returns
// {pat_hi, row index} for each read; a driver task runs one transfer and logs
// every acknowledged beat, and scenario tasks compare the log and outputs
// against hand-derived values.
// -----------------------------------------------------------------------------
module tb_bmp_xfer_unit;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          is_store = 1'b0;
  logic [15:0]   base_addr = '0;
  logic [1535:0] bd_data = '0;
  logic [1535:0] bs_data;
  logic          busy, done, mem_req, mem_we;
  logic [15:0]   mem_addr;
  logic [23:0]   mem_wdata, mem_rdata;
  logic          mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  pat_hi = 8'hA5;
  logic [15:0] cur_base = '0;

  // Memory model: row r of the current transfer reads back {pat_hi, r}.
  assign mem_rdata = {pat_hi, 16'(mem_addr - cur_base)};

  bmp_xfer_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .base_addr (base_addr),
    .bd_data   (bd_data),
    .bs_data   (bs_data),
    .busy      (busy),
    .done      (done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  // Beat log and per-transfer observations filled in by run_xfer.
  logic [15:0] q_addr[$];
  logic [23:0] q_wdata[$];
  logic        q_we[$];
  int          done_cycle, hold_err, stall_cnt;
  logic        bs_early, busy_in_done, chain_busy;
  logic [15:0] chain_addr;

  function automatic logic [1535:0] exp_load(input logic [7:0] hi);
    logic [1535:0] v;
    v = '0;
    for (int r = 0; r < 64; r++) v[(63-r)*24 +: 24] = {hi, 16'(r)};
    return v;
  endfunction

  // X shape: each row marks column c and its mirror, c sweeping 0..23.
  function automatic logic [1535:0] x_bitmap();
    logic [1535:0] v;
    int c;
    v = '0;
    for (int r = 0; r < 64; r++) begin
      c = (r * 23) / 63;
      v[(63-r)*24 + 23 - c] = 1'b1;
      v[(63-r)*24 + c]      = 1'b1;
    end
    return v;
  endfunction

  // Runs one transfer. Cycle 1 is the cycle after the start edge. Returns at
  // the negedge of the done cycle, or (chain) one cycle after re-starting in
  // the done cycle, or (abort_after>0) just after asserting reset.
  task automatic run_xfer(input bit launch, input bit store, input logic [15:0] base,
                          input logic [1535:0] bd, input int ack_pct, input int mid_pulse,
                          input int abort_after, input bit chain, input logic [15:0] chain_base);
    logic [1535:0] bs_snap;
    logic [15:0]   p_addr;
    logic [23:0]   p_wd;
    bit            p_stall, ack_now;
    q_addr.delete(); q_wdata.delete(); q_we.delete();
    done_cycle = 0; hold_err = 0; stall_cnt = 0; bs_early = 1'b0;
    busy_in_done = 1'b1; chain_busy = 1'b0; chain_addr = '0;
    p_stall = 1'b0; p_addr = '0; p_wd = '0;
    cur_base = base;
    if (launch) begin
      @(negedge clk);
      start = 1'b1; is_store = store; base_addr = base; bd_data = bd;
      @(negedge clk);
      start = 1'b0; bd_data = '0;
    end
    bs_snap = bs_data;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (done) begin
        done_cycle = cyc;
        busy_in_done = busy;
        mem_ack = 1'b0;
        if (chain) begin
          start = 1'b1; is_store = 1'b0; base_addr = chain_base;
          cur_base = chain_base; pat_hi = ~pat_hi;
          @(negedge clk);
          start = 1'b0;
          chain_busy = busy;
          chain_addr = mem_addr;
        end
        return;
      end
      if (bs_data !== bs_snap) bs_early = 1'b1;
      if (p_stall && (mem_addr !== p_addr || mem_wdata !== p_wd)) hold_err++;
      if (abort_after > 0 && q_addr.size() == abort_after) begin
        mem_ack = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        return;
      end
      if (mid_pulse == cyc) begin
        start = 1'b1; is_store = ~store; base_addr = 16'hDEAD;
      end else begin
        start = 1'b0;
      end
      ack_now = ($urandom_range(99) < ack_pct);
      mem_ack = ack_now;
      if (mem_req && ack_now) begin
        q_addr.push_back(mem_addr);
        q_wdata.push_back(mem_wdata);
        q_we.push_back(mem_we);
      end
      if (mem_req && !ack_now) stall_cnt++;
      p_stall = mem_req && !ack_now;
      p_addr  = mem_addr;
      p_wd    = mem_wdata;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, mem_req, mem_we} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, mem_req, mem_we});
    end
    checks++;
    if (mem_addr !== 16'h0 || mem_wdata !== 24'h0) begin
      errors++; $display("FAIL reset_mem: got addr %h wdata %h expected 0/0", mem_addr, mem_wdata);
    end
    checks++;
    if (bs_data !== '0) begin
      errors++; $display("FAIL reset_bs: got nonzero bs_data expected 0");
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load();
    logic [1535:0] exp;
    exp = exp_load(8'hA5);
    pat_hi = 8'hA5;
    run_xfer(1'b1, 1'b0, 16'h0100, '0, 100, 0, 0, 1'b0, 16'h0);
    checks++;
    if (done_cycle !== 65) begin
      errors++; $display("FAIL load_latency: got %0d expected 65", done_cycle);
    end
    checks++;
    if (q_addr.size() !== 64) begin
      errors++; $display("FAIL load_beats: got %0d expected 64", q_addr.size());
    end
    checks++;
    if (busy_in_done !== 1'b0) begin
      errors++; $display("FAIL load_busy_in_done: got %b expected 0", busy_in_done);
    end
    checks++;
    if (bs_data[1535 -: 24] !== 24'hA50000) begin
      errors++; $display("FAIL load_row0: got %h expected a50000", bs_data[1535 -: 24]);
    end
    checks++;
    if (bs_data[23:0] !== 24'hA5003F) begin
      errors++; $display("FAIL load_row63: got %h expected a5003f", bs_data[23:0]);
    end
    checks++;
    if (bs_data !== exp) begin
      errors++; $display("FAIL load_bitmap: got %h expected %h", bs_data[1535 -: 96], exp[1535 -: 96]);
    end
    for (int i = 0; i < q_addr.size(); i++) begin
      checks++;
      if (q_addr[i] !== 16'h0100 + 16'(i) || q_we[i] !== 1'b0) begin
        errors++; $display("FAIL load_addr[%0d]: got %h we %b expected %h we 0", i, q_addr[i], q_we[i], 16'h0100 + 16'(i));
      end
    end
  endtask

  task automatic test_store();
    logic [1535:0] xb, prev_bs;
    xb = x_bitmap();
    prev_bs = exp_load(8'hA5);
    run_xfer(1'b1, 1'b1, 16'h2000, xb, 50, 0, 0, 1'b0, 16'h0);
    checks++;
    if (q_addr.size() !== 64) begin
      errors++; $display("FAIL store_beats: got %0d expected 64", q_addr.size());
    end
    checks++;
    if (hold_err !== 0) begin
      errors++; $display("FAIL store_hold: got %0d unstable stalls expected 0", hold_err);
    end
    checks++;
    if (done_cycle !== 65 + stall_cnt) begin
      errors++; $display("FAIL store_latency: got %0d expected %0d", done_cycle, 65 + stall_cnt);
    end
    checks++;
    if (q_wdata.size() > 0 && q_wdata[0] !== 24'h800001) begin
      errors++; $display("FAIL store_row0: got %h expected 800001", q_wdata[0]);
    end
    checks++;
    if (bs_data !== prev_bs) begin
      errors++; $display("FAIL store_bs_kept: got %h expected %h", bs_data[1535 -: 96], prev_bs[1535 -: 96]);
    end
    for (int i = 0; i < q_addr.size(); i++) begin
      checks++;
      if (q_addr[i] !== 16'h2000 + 16'(i) || q_wdata[i] !== xb[(63-i)*24 +: 24] || q_we[i] !== 1'b1) begin
        errors++; $display("FAIL store_beat[%0d]: got %h/%h/%b expected %h/%h/1", i, q_addr[i], q_wdata[i], q_we[i], 16'h2000 + 16'(i), xb[(63-i)*24 +: 24]);
      end
    end
  endtask

  task automatic test_wrap();
    pat_hi = 8'hA5;
    run_xfer(1'b1, 1'b0, 16'hFFF0, '0, 100, 0, 0, 1'b0, 16'h0);
    checks++;
    if (done_cycle !== 65 || q_addr.size() !== 64) begin
      errors++; $display("FAIL wrap_len: got %0d/%0d expected 65/64", done_cycle, q_addr.size());
    end
    checks++;
    if (q_addr.size() == 64 && (q_addr[15] !== 16'hFFFF || q_addr[16] !== 16'h0000 || q_addr[63] !== 16'h002F)) begin
      errors++; $display("FAIL wrap_edges: got %h %h %h expected ffff 0000 002f", q_addr[15], q_addr[16], q_addr[63]);
    end
    for (int i = 0; i < q_addr.size(); i++) begin
      checks++;
      if (q_addr[i] !== 16'hFFF0 + 16'(i)) begin
        errors++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, q_addr[i], 16'hFFF0 + 16'(i));
      end
    end
    checks++;
    if (bs_data !== exp_load(8'hA5)) begin
      errors++; $display("FAIL wrap_bitmap: got %h expected a50000...", bs_data[1535 -: 24]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1535:0] exp2;
    pat_hi = 8'hA5;
    // Mid-transfer start (with opposite mode and a bogus address) must be ignored.
    run_xfer(1'b1, 1'b0, 16'h0400, '0, 100, 10, 0, 1'b1, 16'h0500);
    checks++;
    if (done_cycle !== 65) begin
      errors++; $display("FAIL b2b_first_latency: got %0d expected 65", done_cycle);
    end
    checks++;
    if (q_addr.size() !== 64 || q_addr[63] !== 16'h043F || q_we.sum() !== 0) begin
      errors++; $display("FAIL b2b_first_beats: got %0d beats last %h expected 64 beats last 043f, no writes", q_addr.size(), q_addr[63]);
    end
    checks++;
    if (chain_busy !== 1'b1 || chain_addr !== 16'h0500) begin
      errors++; $display("FAIL b2b_restart: got busy %b addr %h expected busy 1 addr 0500", chain_busy, chain_addr);
    end
    checks++;
    if (bs_data !== exp_load(8'hA5)) begin
      errors++; $display("FAIL b2b_first_bs: got %h expected a50000", bs_data[1535 -: 24]);
    end
    // Drain the chained load; old bitmap must stay until its done cycle.
    exp2 = exp_load(8'h5A);
    run_xfer(1'b0, 1'b0, 16'h0500, '0, 100, 0, 0, 1'b0, 16'h0);
    checks++;
    if (done_cycle !== 65) begin
      errors++; $display("FAIL b2b_second_latency: got %0d expected 65", done_cycle);
    end
    checks++;
    if (bs_early !== 1'b0) begin
      errors++; $display("FAIL b2b_bs_atomic: got early change %b expected 0", bs_early);
    end
    checks++;
    if (bs_data !== exp2) begin
      errors++; $display("FAIL b2b_second_bs: got %h expected 5a0000", bs_data[1535 -: 24]);
    end
  endtask

  task automatic test_abort();
    logic saw_done;
    pat_hi = 8'hA5;
    run_xfer(1'b1, 1'b0, 16'h0600, '0, 100, 0, 10, 1'b0, 16'h0);
    checks++;
    if ({busy, done, mem_req, mem_we} !== 4'b0000 || mem_addr !== 16'h0 || mem_wdata !== 24'h0) begin
      errors++; $display("FAIL abort_outputs: got %b addr %h wdata %h expected all 0", {busy, done, mem_req, mem_we}, mem_addr, mem_wdata);
    end
    checks++;
    if (bs_data !== '0) begin
      errors++; $display("FAIL abort_bs: got %h expected 0", bs_data[1535 -: 24]);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: got %b expected 0", saw_done);
    end
    run_xfer(1'b1, 1'b0, 16'h0700, '0, 100, 0, 0, 1'b0, 16'h0);
    checks++;
    if (done_cycle !== 65 || bs_data !== exp_load(8'hA5)) begin
      errors++; $display("FAIL abort_reload: got latency %0d row0 %h expected 65 a50000", done_cycle, bs_data[1535 -: 24]);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_wrap();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
